fdivsqrt_otfc4_seq: RTL and testbench

Sequential radix-4 on-the-fly conversion (OTFC) register stage for the divide/square-root unit. It holds the partial root/quotient U, its decrement UM = U − ulp, and the position mask C. It updates them once per accepted signed digit. Its registered outputs feed the radix-4 F addend generator in the same iteration, so it sits directly upstream of that block. A small FSM sequences init, iteration count, completion and abort.

---
 rtl/fdivsqrt_otfc4_seq_pkg.sv | 16 +
 rtl/fdivsqrt_otfc4_update.sv | 40 ++++
 rtl/fdivsqrt_otfc4_seq.sv | 105 ++++++++++
 tb/tb_fdivsqrt_otfc4_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fdivsqrt_otfc4_seq_pkg.sv
// Shared types for the radix-4 on-the-fly conversion stage of the divide/sqrt unit.
package fdivsqrt_otfc4_seq_pkg;

    typedef struct packed {
        int unsigned DIVb;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{DIVb: 12};

    typedef enum logic [1:0] {
        OTFC_IDLE = 2'd0,
        OTFC_BUSY = 2'd1,
        OTFC_DONE = 2'd2
    } fdivsqrt_otfc_state_t;

endpackage

// File: rtl/fdivsqrt_otfc4_update.sv
// One radix-4 OTFC step: maps (U, UM, C, digit) to the next (U, UM, C) using only ORs.
module fdivsqrt_otfc4_update #(
    parameter int W = 16
) (
    input  logic [W-1:0] u_i,
    input  logic [W-1:0] um_i,
    input  logic [W-1:0] c_i,
    input  logic [3:0]   udigit_i,
    output logic [W-1:0] un_o,
    output logic [W-1:0] umn_o,
    output logic [W-1:0] cn_o
);

    logic [W-1:0] k;

    always_comb begin
        cn_o  = {2'b11, c_i[W-1:2]};
        // Cn is a run of ones from the top, so K is its lowest set bit.
        k     = cn_o & ~(cn_o << 1);
        un_o  = u_i;
        umn_o = um_i;
        if (udigit_i[3]) begin
            un_o  = u_i | (k << 1);
            umn_o = u_i | k;
        end else if (udigit_i[2]) begin
            un_o  = u_i | k;
            umn_o = u_i;
        end else if (udigit_i[1]) begin
            un_o  = um_i | (k << 1) | k;
            umn_o = um_i | (k << 1);
        end else if (udigit_i[0]) begin
            un_o  = um_i | (k << 1);
            umn_o = um_i | k;
        end else begin
            un_o  = u_i;
            umn_o = um_i | (k << 1) | k;
        end
    end

endmodule

// File: rtl/fdivsqrt_otfc4_seq.sv
// Sequential radix-4 OTFC register stage with an init/iterate/done/abort sequencer.
module fdivsqrt_otfc4_seq
    import fdivsqrt_otfc4_seq_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     start_i,
    input  logic                                     sqrt_i,
    input  logic [$clog2((P.DIVb+4-6)/2+1+1)-1:0]    niter_i,
    input  logic                                     kill_i,
    input  logic                                     digit_valid_i,
    input  logic [3:0]                               udigit_i,
    output logic [P.DIVb+3:0]                        u_o,
    output logic [P.DIVb+3:0]                        um_o,
    output logic [P.DIVb+3:0]                        c_o,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int W       = P.DIVb + 4;
    localparam int MAXITER = (W - 6) / 2 + 1;
    localparam int NW      = $clog2(MAXITER + 1);

    localparam logic [NW-1:0] MAXN     = NW'(MAXITER);
    localparam logic [W-1:0]  C_INIT   = {4'b1111, {(W-4){1'b0}}};
    localparam logic [W-1:0]  U_ONE    = {4'b0001, {(W-4){1'b0}}};

    fdivsqrt_otfc_state_t state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  u_q, u_d, um_q, um_d, c_q, c_d;
    logic [W-1:0]  un, umn, cn;
    logic [NW-1:0] niter_clamped;

    fdivsqrt_otfc4_update #(.W(W)) u_update (
        .u_i      (u_q),
        .um_i     (um_q),
        .c_i      (c_q),
        .udigit_i (udigit_i),
        .un_o     (un),
        .umn_o    (umn),
        .cn_o     (cn)
    );

    assign niter_clamped = (niter_i > MAXN) ? MAXN : niter_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        u_d     = u_q;
        um_d    = um_q;
        c_d     = c_q;
        if (kill_i) begin
            state_d = OTFC_IDLE;
        end else begin
            case (state_q)
                OTFC_IDLE: begin
                    if (start_i) begin
                        c_d     = C_INIT;
                        // Divide seeds UM with -4K of the first digit position.
                        u_d     = sqrt_i ? U_ONE : '0;
                        um_d    = sqrt_i ? '0 : C_INIT;
                        cnt_d   = niter_clamped;
                        state_d = (niter_clamped == '0) ? OTFC_DONE : OTFC_BUSY;
                    end
                end
                OTFC_BUSY: begin
                    if (digit_valid_i) begin
                        u_d   = un;
                        um_d  = umn;
                        c_d   = cn;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == NW'(1)) state_d = OTFC_DONE;
                    end
                end
                OTFC_DONE: state_d = OTFC_IDLE;
                default:   state_d = OTFC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= OTFC_IDLE;
            cnt_q   <= '0;
            u_q     <= '0;
            um_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            u_q     <= u_d;
            um_q    <= um_d;
            c_q     <= c_d;
        end
    end

    assign u_o    = u_q;
    assign um_o   = um_q;
    assign c_o    = c_q;
    assign busy_o = (state_q == OTFC_BUSY);
    assign done_o = (state_q == OTFC_DONE);

endmodule

// File: tb/tb_fdivsqrt_otfc4_seq.sv
// Self-checking bench for fdivsqrt_otfc4_seq with DIVb = 12 (W = 16, MAXITER = 6).
module tb_fdivsqrt_otfc4_seq;
    import fdivsqrt_otfc4_seq_pkg::*;

    localparam int W  = 16;
    localparam int NW = 3;

    localparam logic [3:0] DP2 = 4'b1000;
    localparam logic [3:0] DP1 = 4'b0100;
    localparam logic [3:0] DM1 = 4'b0010;
    localparam logic [3:0] DM2 = 4'b0001;
    localparam logic [3:0] DZ  = 4'b0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          sqrt = 1'b0;
    logic [NW-1:0] niter = '0;
    logic          kill = 1'b0;
    logic          digit_valid = 1'b0;
    logic [3:0]    udigit = 4'b0000;
    logic [W-1:0]  u, um, c;
    logic          busy, done;

    int n_chk = 0;
    int n_fail = 0;

    fdivsqrt_otfc4_seq #(.P('{DIVb: 12})) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .sqrt_i        (sqrt),
        .niter_i       (niter),
        .kill_i        (kill),
        .digit_valid_i (digit_valid),
        .udigit_i      (udigit),
        .u_o           (u),
        .um_o          (um),
        .c_o           (c),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             sqrt;
        logic [NW-1:0]    niter;
        logic             toggle;
        logic [5:0][3:0]  digits;
        logic [W-1:0]     exp_u;
        logic [W-1:0]     exp_um;
        logic [W-1:0]     exp_c;
        int               lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int idx;
        bit seen;
        @(negedge clk);
        start = 1'b1; sqrt = v.sqrt; niter = v.niter; digit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; idx = 0; seen = 1'b0;
        while (cyc <= 20 && !seen) begin
            if (done) begin
                seen = 1'b1;
                chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
                chk({v.name, " U"}, 32'(u), 32'(v.exp_u));
                chk({v.name, " UM"}, 32'(um), 32'(v.exp_um));
                chk({v.name, " C"}, 32'(c), 32'(v.exp_c));
                chk({v.name, " busy with done"}, 32'(busy), 32'd0);
            end else begin
                digit_valid = v.toggle ? ((cyc % 2) == 1) : 1'b1;
                udigit = (idx < 6) ? v.digits[idx] : DZ;
                if (digit_valid && busy) idx++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk({v.name, " done timeout"}, 32'd0, 32'd1);
        digit_valid = 1'b0;
        udigit = DZ;
        @(negedge clk);
        chk({v.name, " done one-cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"sqrt2", 1'b1, 3'd2, 1'b0, {DZ, DZ, DZ, DZ, DM1, DP2}, 16'h1700, 16'h1600, 16'hFF00, 3};
        vecs[1] = '{"div_zero", 1'b0, 3'd1, 1'b0, {DZ, DZ, DZ, DZ, DZ, DZ}, 16'h0000, 16'hFC00, 16'hFC00, 2};
        vecs[2] = '{"stall_clamp", 1'b1, 3'd7, 1'b1, {DP1, DP1, DP1, DP1, DP1, DP1}, 16'h1555, 16'h1554, 16'hFFFF, 12};
        vecs[3] = '{"zero_count", 1'b1, 3'd0, 1'b0, {DZ, DZ, DZ, DZ, DZ, DZ}, 16'h1000, 16'h0000, 16'hF000, 1};
        vecs[4] = '{"multihot", 1'b1, 3'd1, 1'b0, {DZ, DZ, DZ, DZ, DZ, 4'b1010}, 16'h1800, 16'h1400, 16'hFC00, 2};
        vecs[5] = '{"div_m2_p1", 1'b0, 3'd2, 1'b0, {DZ, DZ, DZ, DZ, DP1, DM2}, 16'hF900, 16'hF800, 16'hFF00, 3};
        vecs[6] = '{"div_p2_m1_m2", 1'b0, 3'd3, 1'b0, {DZ, DZ, DZ, DM2, DM1, DP2}, 16'h0680, 16'h0640, 16'hFFC0, 4};

        repeat (2) @(negedge clk);
        chk("reset U", 32'(u), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // kill on the second digit
        @(negedge clk);
        start = 1'b1; sqrt = 1'b1; niter = 3'd3;
        @(negedge clk);
        start = 1'b0; digit_valid = 1'b1; udigit = DP2;
        @(negedge clk);
        chk("kill U after d1", 32'(u), 32'h1800);
        udigit = DP1; kill = 1'b1;
        @(negedge clk);
        kill = 1'b0; digit_valid = 1'b0;
        chk("kill U held", 32'(u), 32'h1800);
        chk("kill UM held", 32'(um), 32'h1400);
        chk("kill busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("kill no done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // start while busy is ignored
        start = 1'b1; sqrt = 1'b1; niter = 3'd2;
        @(negedge clk);
        start = 1'b1; sqrt = 1'b0; niter = 3'd5; digit_valid = 1'b1; udigit = DP2;
        @(negedge clk);
        start = 1'b0;
        chk("restart U", 32'(u), 32'h1800);
        chk("restart busy", 32'(busy), 32'd1);
        udigit = DM1;
        @(negedge clk);
        digit_valid = 1'b0;
        chk("restart done", 32'(done), 32'd1);
        chk("restart U final", 32'(u), 32'h1700);
        @(negedge clk);

        // asynchronous reset mid-operation
        start = 1'b1; sqrt = 1'b1; niter = 3'd3;
        @(negedge clk);
        start = 1'b0; digit_valid = 1'b1; udigit = DP2;
        @(negedge clk);
        digit_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async rst U", 32'(u), 32'd0);
        chk("async rst UM", 32'(um), 32'd0);
        chk("async rst C", 32'(c), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post rst no done", 32'(done), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
